// File: rtl/common_mem_pkg.sv
// Shared widths and the client state encoding for the common-memory client.
package common_mem_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned BANK_W    = 3;
  localparam int unsigned NUM_BANKS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    CHK  = 2'd3
  } state_t;

endpackage

// File: rtl/common_mem_rd_stage.sv
// One-entry registered valid/ready output stage for read data.
// Holds data/last stable while valid is high and the consumer stalls.
module common_mem_rd_stage
  import common_mem_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  // A new word may enter when the stage is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  // Output register: load wins over drain so back-to-back words stream at full rate.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/common_mem_client.sv
// Bus-side initiator for one common-memory port: splits block requests into
// per-word port cycles. Writes go to OWN_BANK, reads stream out via rd_*.
// Optional write verification: define COMMON_MEM_CLIENT_WRCHK_EN.
module common_mem_client
  import common_mem_pkg::*;
#(
  parameter int unsigned OWN_BANK = 0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BANK_W-1:0] mem_rd_od,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              done,
  output logic              err
);

  localparam logic [BANK_W-1:0] OWN_BANK_ID = BANK_W'(OWN_BANK);

  state_t              state, state_nx;
  logic [BANK_W-1:0]   bank_q;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     cnt_q;
  logic                done_q, done_nx;
  logic                accept, beat, issue, advance;
  logic                last_idx, stage_ready;

`ifdef COMMON_MEM_CLIENT_WRCHK_EN
  localparam int unsigned WORDS = 2 ** ADDR_W;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   shadow [WORDS];
  logic                chk_step;
  logic                err_q;
`endif

  // cnt counts words handled so far in the current phase; last word when it equals len.
  assign last_idx = (cnt_q == {1'b0, len_q});

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and memory-port / handshake drive.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    wd_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_rd_od = OWN_BANK_ID;
    mem_wd    = '0;
    accept    = 1'b0;
    beat      = 1'b0;
    issue     = 1'b0;
    advance   = 1'b0;
    done_nx   = 1'b0;
`ifdef COMMON_MEM_CLIENT_WRCHK_EN
    chk_step  = 1'b0;
`endif
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = req_wr ? WR : RD;
        end
      end
      WR: begin
        wd_ready = 1'b1;
        mem_we   = wd_valid;
        mem_addr = ptr_q;
        mem_wd   = wd_data;
        if (wd_valid) begin
          beat    = 1'b1;
          advance = 1'b1;
          if (last_idx) begin
`ifdef COMMON_MEM_CLIENT_WRCHK_EN
            state_nx = CHK;
`else
            state_nx = IDLE;
            done_nx  = 1'b1;
`endif
          end
        end
      end
      RD: begin
        mem_addr  = ptr_q;
        mem_rd_od = bank_q;
        // A fetch is pending while cnt <= len words have been issued.
        if ((cnt_q <= {1'b0, len_q}) && stage_ready) begin
          issue   = 1'b1;
          advance = 1'b1;
        end
        if (rd_valid && rd_ready && rd_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
`ifdef COMMON_MEM_CLIENT_WRCHK_EN
      CHK: begin
        mem_addr = ptr_q;
        chk_step = 1'b1;
        advance  = 1'b1;
        if (last_idx) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Burst bookkeeping: latch request fields, step ptr/cnt per word, register done.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
      len_q  <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_nx;
      if (accept) begin
        bank_q <= req_bank;
        len_q  <= req_len;
        ptr_q  <= req_base;
        cnt_q  <= '0;
      end
`ifdef COMMON_MEM_CLIENT_WRCHK_EN
      // Final write beat rewinds to the burst start for the verification pass.
      else if (beat && last_idx) begin
        ptr_q <= base_q;
        cnt_q <= '0;
      end
`endif
      else if (advance) begin
        ptr_q <= ptr_q + ADDR_W'(1);
        cnt_q <= cnt_q + (ADDR_W + 1)'(1);
      end
    end
  end

`ifdef COMMON_MEM_CLIENT_WRCHK_EN
  // Burst base and sticky mismatch flag, cleared on each new request.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      base_q <= req_base;
      err_q  <= 1'b0;
    end else if (chk_step && (mem_rd != shadow[cnt_q[ADDR_W-1:0]])) begin
      err_q <= 1'b1;
    end
  end

  // Shadow copy of each written word, indexed by beat number.
  always_ff @(posedge clk_in) begin
    if (beat) shadow[cnt_q[ADDR_W-1:0]] <= wd_data;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign done = done_q;

  common_mem_rd_stage u_rd_stage (
    .clk_in    (clk_in),
    .rst       (rst),
    .load      (issue),
    .load_data (mem_rd),
    .load_last (last_idx),
    .in_ready  (stage_ready),
    .out_valid (rd_valid),
    .out_ready (rd_ready),
    .out_data  (rd_data),
    .out_last  (rd_last)
  );

endmodule

// File: tb/tb_common_mem_client.sv
// Directed self-checking bench for common_mem_client with an 8x4 memory model.
module tb_common_mem_client;
  import common_mem_pkg::*;

  localparam int unsigned OWN = 2;
`ifdef COMMON_MEM_CLIENT_WRCHK_EN
  localparam int CHK_ON = 1;
`else
  localparam int CHK_ON = 0;
`endif

  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;
  localparam logic [31:0] WD = 32'hD0D0_0004;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_bank;
  logic [1:0]  req_base, req_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [2:0]  mem_rd_od;
  logic [31:0] mem_wd, mem_rd;
  logic        done, err;

  logic [31:0] mem [8][4];
  logic        tb_we;
  logic [2:0]  tb_bank;
  logic [1:0]  tb_addr;
  logic [31:0] tb_data;

  int checks = 0;
  int passes = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (mem_we) mem[mem_rd_od][mem_addr] <= mem_wd;
    if (tb_we)  mem[tb_bank][tb_addr]    <= tb_data;
  end
  assign mem_rd = mem[mem_rd_od][mem_addr];

  common_mem_client #(.OWN_BANK(OWN)) dut (
    .clk_in(clk_in), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_bank(req_bank), .req_base(req_base), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_rd_od(mem_rd_od), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .done(done), .err(err)
  );

  task automatic test_reset();
    logic [31:0] pre [4];
    pre = '{WA, WB, WC, WD};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      tb_we = 1'b1; tb_bank = 3'd5; tb_addr = 2'(i); tb_data = pre[i];
    end
    @(negedge clk_in);
    tb_we = 1'b0;
    #1;
    checks++; if ({req_ready, wd_ready, rd_valid, rd_last, done, err} !== 6'b100000)
      $display("FAIL reset_flags: got %b expected 100000", {req_ready, wd_ready, rd_valid, rd_last, done, err}); else passes++;
    checks++; if ({mem_we, mem_addr, mem_rd_od, mem_wd, rd_data} !== {1'b0, 2'd0, 3'd2, 32'd0, 32'd0})
      $display("FAIL reset_port: got we=%b addr=%0d od=%0d wd=%h rd=%h expected 0 0 2 0 0", mem_we, mem_addr, mem_rd_od, mem_wd, rd_data); else passes++;
    @(negedge clk_in);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b expected 1", req_ready); else passes++;
  endtask

  task automatic test_write();
    logic [31:0] w [4];
    int lat;
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    @(negedge clk_in);
    req_valid = 1'b1; req_wr = 1'b1; req_bank = 3'd7; req_base = 2'd0; req_len = 2'd3;
    @(negedge clk_in);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wd_valid = 1'b1; wd_data = w[i];
      #1;
      checks++; if ({wd_ready, mem_we, mem_addr, mem_rd_od, mem_wd} !== {1'b1, 1'b1, 2'(i), 3'd2, w[i]})
        $display("FAIL write_beat%0d: got rdy=%b we=%b addr=%0d od=%0d wd=%h expected 1 1 %0d 2 %h",
                 i, wd_ready, mem_we, mem_addr, mem_rd_od, mem_wd, i, w[i]); else passes++;
      @(negedge clk_in);
    end
    wd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin @(negedge clk_in); lat++; end
    checks++; if (lat !== 1 + CHK_ON * 4) $display("FAIL write_done_latency: got %0d expected %0d", lat, 1 + CHK_ON * 4); else passes++;
    checks++; if ({req_ready, err} !== 2'b10) $display("FAIL write_done_idle: got rdy/err %b expected 10", {req_ready, err}); else passes++;
    @(negedge clk_in);
    checks++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", done); else passes++;
    checks++; if ({mem[2][0], mem[2][1], mem[2][2], mem[2][3]} !== {w[0], w[1], w[2], w[3]})
      $display("FAIL write_contents: got %h %h %h %h expected 11 22 33 44", mem[2][0], mem[2][1], mem[2][2], mem[2][3]); else passes++;
  endtask

  task automatic test_read_own();
    @(negedge clk_in);
    req_valid = 1'b1; req_wr = 1'b0; req_bank = 3'd2; req_base = 2'd3; req_len = 2'd0; rd_ready = 1'b1;
    @(negedge clk_in);
    req_valid = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) $display("FAIL own_read_early: got %b expected 0", rd_valid); else passes++;
    @(negedge clk_in); #1;
    checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, 1'b1, 32'h44})
      $display("FAIL own_read_word: got v=%b l=%b d=%h expected 1 1 44", rd_valid, rd_last, rd_data); else passes++;
    @(negedge clk_in); #1;
    checks++; if ({done, req_ready, rd_valid} !== 3'b110) $display("FAIL own_read_done: got %b expected 110", {done, req_ready, rd_valid}); else passes++;
  endtask

  task automatic test_read();
    logic [31:0] e [4];
    e = '{WC, WD, WA, WB};
    @(negedge clk_in);
    req_valid = 1'b1; req_wr = 1'b0; req_bank = 3'd5; req_base = 2'd2; req_len = 2'd3; rd_ready = 1'b1;
    @(negedge clk_in);
    req_valid = 1'b0;
    #1;
    checks++; if ({rd_valid, mem_addr, mem_rd_od} !== {1'b0, 2'd2, 3'd5})
      $display("FAIL read_first_addr: got v=%b addr=%0d od=%0d expected 0 2 5", rd_valid, mem_addr, mem_rd_od); else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in); #1;
      checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, (i == 3), e[i]})
        $display("FAIL read_word%0d: got v=%b l=%b d=%h expected 1 %0d %h", i, rd_valid, rd_last, rd_data, (i == 3), e[i]); else passes++;
    end
    @(negedge clk_in); #1;
    checks++; if ({done, req_ready, rd_valid} !== 3'b110) $display("FAIL read_done: got %b expected 110", {done, req_ready, rd_valid}); else passes++;
  endtask

  task automatic test_read_stall();
    logic [31:0] e [4];
    logic [31:0] held;
    bit held_last, stalled, last_hs, seen_done;
    int got;
    e = '{WA, WB, WC, WD};
    got = 0; stalled = 0; last_hs = 0; seen_done = 0; held = '0; held_last = 0;
    @(negedge clk_in);
    req_valid = 1'b1; req_wr = 1'b0; req_bank = 3'd5; req_base = 2'd0; req_len = 2'd3;
    @(negedge clk_in);
    req_valid = 1'b0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      rd_ready = (k % 2 == 1);
      #1;
      if (done === 1'b1) begin
        seen_done = 1;
        checks++; if ({last_hs, 3'(got)} !== {1'b1, 3'd4}) $display("FAIL stall_done: got last_hs=%b words=%0d expected 1 4", last_hs, got); else passes++;
      end else begin
        if (stalled) begin
          checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, held_last, held})
            $display("FAIL stall_hold: got v=%b l=%b d=%h expected 1 %b %h", rd_valid, rd_last, rd_data, held_last, held); else passes++;
        end
        last_hs = 0;
        if (rd_valid && rd_ready) begin
          if (got < 4) begin
            checks++; if ({rd_last, rd_data} !== {(got == 3), e[got]})
              $display("FAIL stall_word%0d: got l=%b d=%h expected %0d %h", got, rd_last, rd_data, (got == 3), e[got]); else passes++;
          end else begin
            checks++; $display("FAIL stall_extra_word: got %h expected none", rd_data);
          end
          last_hs = rd_last;
          got++;
        end
        stalled = rd_valid && !rd_ready;
        held = rd_data; held_last = rd_last;
      end
      @(negedge clk_in);
    end
    if (!seen_done) begin
      checks++; $display("FAIL stall_timeout: got no done expected done within 40 cycles");
    end
    rd_ready = 1'b1;
  endtask

  task automatic test_wd_gaps();
    logic [5:0] pat;
    int nb, lat;
    pat = 6'b100100;
    nb = 0;
    @(negedge clk_in);
    wd_valid = 1'b1; wd_data = 32'hDEAD_BEEF;
    #1;
    checks++; if ({mem_we, wd_ready} !== 2'b00) $display("FAIL idle_wd_ignored: got we/rdy %b expected 00", {mem_we, wd_ready}); else passes++;
    req_valid = 1'b1; req_wr = 1'b1; req_base = 2'd1; req_len = 2'd1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      req_valid = (k < 3); req_wr = 1'b0;
      wd_valid = pat[k];
      wd_data = pat[k] ? (nb == 0 ? 32'h55 : 32'h66) : 32'hDEAD_BEEF;
      #1;
      checks++; if ({mem_we, mem_addr, req_ready} !== {pat[k], 2'(1 + nb), 1'b0})
        $display("FAIL gap_cycle%0d: got we=%b addr=%0d rdy=%b expected %b %0d 0", k, mem_we, mem_addr, req_ready, pat[k], 1 + nb); else passes++;
      if (pat[k]) nb++;
    end
    @(negedge clk_in);
    wd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin @(negedge clk_in); lat++; end
    checks++; if (lat !== 1 + CHK_ON * 2) $display("FAIL gap_done_latency: got %0d expected %0d", lat, 1 + CHK_ON * 2); else passes++;
    checks++; if ({mem[2][0], mem[2][1], mem[2][2], mem[2][3]} !== {32'h11, 32'h55, 32'h66, 32'h44})
      $display("FAIL gap_contents: got %h %h %h %h expected 11 55 66 44", mem[2][0], mem[2][1], mem[2][2], mem[2][3]); else passes++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_in);
    req_valid = 1'b1; req_wr = 1'b1; req_base = 2'd0; req_len = 2'd3;
    @(negedge clk_in);
    req_valid = 1'b0; wd_valid = 1'b1; wd_data = 32'h71;
    @(negedge clk_in);
    wd_data = 32'h72;
    @(negedge clk_in);
    wd_data = 32'h73; rst = 1'b1;
    #1;
    checks++; if ({req_ready, wd_ready, mem_we, mem_addr, mem_rd_od, mem_wd, done, rd_valid} !== {1'b1, 1'b0, 1'b0, 2'd0, 3'd2, 32'd0, 1'b0, 1'b0})
      $display("FAIL midreset_outputs: got rdy=%b wrdy=%b we=%b addr=%0d od=%0d wd=%h done=%b expected 1 0 0 0 2 0 0",
               req_ready, wd_ready, mem_we, mem_addr, mem_rd_od, mem_wd, done); else passes++;
    @(negedge clk_in);
    rst = 1'b0; wd_valid = 1'b0;
    #1;
    checks++; if ({mem[2][0], mem[2][1], mem[2][2], mem[2][3]} !== {32'h71, 32'h72, 32'h66, 32'h44})
      $display("FAIL midreset_contents: got %h %h %h %h expected 71 72 66 44", mem[2][0], mem[2][1], mem[2][2], mem[2][3]); else passes++;
  endtask

  task automatic test_err();
    logic [31:0] w [4];
    int lat;
    w = '{32'h81, 32'h82, 32'h83, 32'h84};
    @(negedge clk_in);
    req_valid = 1'b1; req_wr = 1'b1; req_base = 2'd0; req_len = 2'd3;
    @(negedge clk_in);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wd_valid = 1'b1; wd_data = w[i];
      @(negedge clk_in);
    end
    wd_valid = 1'b0;
    lat = 1;
`ifdef COMMON_MEM_CLIENT_WRCHK_EN
    tb_we = 1'b1; tb_bank = 3'd2; tb_addr = 2'd1; tb_data = 32'hBAD0_0BAD;
    @(negedge clk_in);
    tb_we = 1'b0; lat = 2;
`endif
    while (done !== 1'b1 && lat < 12) begin @(negedge clk_in); lat++; end
    checks++; if ({done, err} !== {1'b1, 1'(CHK_ON)}) $display("FAIL err_at_done: got done/err %b expected 1%0d", {done, err}, CHK_ON); else passes++;
    req_valid = 1'b1; req_wr = 1'b0; req_bank = 3'd5; req_base = 2'd0; req_len = 2'd0;
    @(negedge clk_in);
    req_valid = 1'b0;
    #1;
    checks++; if (err !== 1'b0) $display("FAIL err_cleared: got %b expected 0", err); else passes++;
    lat = 0;
    while (done !== 1'b1 && lat < 12) begin @(negedge clk_in); lat++; end
    checks++; if (done !== 1'b1) $display("FAIL err_read_done: got %b expected 1", done); else passes++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_bank = '0; req_base = '0; req_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b1;
    tb_we = 1'b0; tb_bank = '0; tb_addr = '0; tb_data = '0;
    test_reset();
    test_write();
    test_read_own();
    test_read();
    test_read_stall();
    test_wd_gaps();
    test_reset_mid();
    test_err();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
